snail_stream_sched: RTL and testbench



---
 rtl/snail_pkg.sv | 32 +++
 rtl/snail_rr_arb.sv | 31 +++
 rtl/snail_stream_sched.sv | 88 ++++++++
 tb/tb_snail_stream_sched.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/snail_pkg.sv
// Shared types and the "1101" Mealy step function for the snail stream scheduler.
package snail_pkg;

  localparam int unsigned HIT_CNT_W = 8;

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } snail_state_t;

  typedef struct packed {
    snail_state_t nxt;
    logic         match;
  } snail_step_t;

  // One detector step; a hit leaves the stream in S1 so overlapping matches are found.
  function automatic snail_step_t snail_step(input snail_state_t state, input logic b);
    snail_step_t r;
    r.match = b && (state == S3);
    unique case (state)
      S0:      r.nxt = b ? S1 : S0;
      S1:      r.nxt = b ? S2 : S0;
      S2:      r.nxt = b ? S2 : S3;
      S3:      r.nxt = b ? S1 : S0;
      default: r.nxt = S0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/snail_rr_arb.sv
// Round-robin grant: first eligible stream at or after ptr, wrapping modulo NCH.
module snail_rr_arb
  import snail_pkg::*;
#(
  parameter int unsigned NCH = 4,
  parameter int unsigned CW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] eligible,
  input  logic [CW-1:0]  ptr,
  output logic [NCH-1:0] grant,
  output logic [CW-1:0]  idx,
  output logic           any
);

  always_comb begin
    logic [CW-1:0] j;
    j     = '0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int unsigned k = 0; k < NCH; k++) begin
      j = CW'((32'(ptr) + k) % NCH);
      if (!any && eligible[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = j;
      end
    end
  end

endmodule

// File: rtl/snail_stream_sched.sv
// Time-multiplexed "1101" detector over NCH serial streams with round-robin acceptance.
// Optional per-stream saturating hit counters when SNAIL_HIT_COUNT_EN is defined.
module snail_stream_sched
  import snail_pkg::*;
#(
  parameter  int unsigned NCH = 4,
  localparam int unsigned CW  = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] req_valid,
  input  logic [NCH-1:0] req_bit,
  output logic [NCH-1:0] req_ready,
  input  logic [NCH-1:0] ch_clear,
  output logic           hit,
  output logic [CW-1:0]  hit_ch,
  output logic           busy
`ifdef SNAIL_HIT_COUNT_EN
  ,
  input  logic [CW-1:0]        cnt_sel,
  output logic [HIT_CNT_W-1:0] hit_cnt
`endif
);

  logic [NCH-1:0] eligible;
  logic [NCH-1:0] grant;
  logic [CW-1:0]  gidx;
  logic           gany;
  logic [CW-1:0]  rr_ptr;
  snail_state_t   ctx [NCH];
  snail_step_t    stp;

  // A stream being cleared is never granted, so its bit stays pending.
  assign eligible  = req_valid & ~ch_clear;
  assign req_ready = grant;

  snail_rr_arb #(
    .NCH (NCH),
    .CW  (CW)
  ) u_arb (
    .eligible (eligible),
    .ptr      (rr_ptr),
    .grant    (grant),
    .idx      (gidx),
    .any      (gany)
  );

  always_comb stp = snail_step(ctx[gidx], req_bit[gidx]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NCH; i++) ctx[i] <= S0;
      rr_ptr <= '0;
      hit    <= 1'b0;
      hit_ch <= '0;
      busy   <= 1'b0;
    end else begin
      busy <= gany;
      hit  <= gany && stp.match;
      if (gany && stp.match) hit_ch <= gidx;
      if (gany) rr_ptr <= (gidx == CW'(NCH - 1)) ? '0 : gidx + 1'b1;
      for (int unsigned i = 0; i < NCH; i++) begin
        if (ch_clear[i])                     ctx[i] <= S0;
        else if (gany && (gidx == CW'(i)))   ctx[i] <= stp.nxt;
      end
    end
  end

`ifdef SNAIL_HIT_COUNT_EN
  logic [HIT_CNT_W-1:0] cnt [NCH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NCH; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (ch_clear[i])
          cnt[i] <= '0;
        else if (gany && stp.match && (gidx == CW'(i)) && (cnt[i] != '1))
          cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  assign hit_cnt = cnt[cnt_sel];
`endif

endmodule

// File: tb/tb_snail_stream_sched.sv
// Scoreboard bench for snail_stream_sched: directed vectors push expected grants/hits,
// a negedge monitor pops and compares whenever a transfer or hit is presented.
module tb_snail_stream_sched;
  import snail_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req_valid, req_bit, req_ready, ch_clear;
  logic       hit;
  logic [1:0] hit_ch;
  logic       busy;
`ifdef SNAIL_HIT_COUNT_EN
  logic [1:0] cnt_sel;
  logic [7:0] hit_cnt;
`endif

  always #5 clk = ~clk;

  snail_stream_sched #(.NCH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_bit   (req_bit),
    .req_ready (req_ready),
    .ch_clear  (ch_clear),
    .hit       (hit),
    .hit_ch    (hit_ch),
    .busy      (busy)
`ifdef SNAIL_HIT_COUNT_EN
    ,
    .cnt_sel   (cnt_sel),
    .hit_cnt   (hit_cnt)
`endif
  );

  typedef struct {
    int ch;
    int cyc;
  } exp_t;

  exp_t gq[$];
  exp_t hq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_n  = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc_n++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: one transfer and at most one hit can appear per cycle.
  always @(negedge clk) begin
    int   g;
    exp_t e;
    if (mon_en) begin
      if (|(req_valid & req_ready)) begin
        g = -1;
        for (int i = 0; i < 4; i++) if (req_ready[i]) g = i;
        checks++;
        if (gq.size() == 0) begin
          errors++;
          $display("FAIL grant: unexpected transfer on stream %0d at cycle %0d", g, cyc_n);
        end else begin
          e = gq.pop_front();
          if (e.ch != g || e.cyc != cyc_n) begin
            errors++;
            $display("FAIL grant: got stream %0d cycle %0d expected stream %0d cycle %0d",
                     g, cyc_n, e.ch, e.cyc);
          end
        end
      end
      if (hit) begin
        checks++;
        if (hq.size() == 0) begin
          errors++;
          $display("FAIL hit: unexpected hit on stream %0d at cycle %0d", hit_ch, cyc_n);
        end else begin
          e = hq.pop_front();
          if (e.ch != int'(hit_ch) || e.cyc != cyc_n) begin
            errors++;
            $display("FAIL hit: got stream %0d cycle %0d expected stream %0d cycle %0d",
                     hit_ch, cyc_n, e.ch, e.cyc);
          end
        end
      end
    end
  end

  // One cycle of stimulus; g = expected granted stream (-1 none), h = expected hit stream.
  task automatic step(input logic [3:0] v, input logic [3:0] b, input logic [3:0] clr,
                      input int g, input int h);
    logic [3:0] er;
    exp_t       e;
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    req_valid = v;
    req_bit   = b;
    ch_clear  = clr;
    #1;
    chk("req_ready", 32'(req_ready), 32'(er));
    if (g >= 0) begin
      e.ch = g; e.cyc = cyc_n; gq.push_back(e);
    end
    if (h >= 0) begin
      e.ch = h; e.cyc = cyc_n + 1; hq.push_back(e);
    end
    @(posedge clk);
    #1;
    req_valid = '0;
    ch_clear  = '0;
    chk("busy", 32'(busy), 32'(g >= 0));
  endtask

  task automatic idle();
    step(4'h0, 4'h0, 4'h0, -1, -1);
  endtask

  task automatic drained(input string name);
    chk({name, "_grant_q"}, 32'(gq.size()), 32'd0);
    chk({name, "_hit_q"}, 32'(hq.size()), 32'd0);
  endtask

  initial begin
    exp_t e;
    reset     = 1'b1;
    req_valid = '0;
    req_bit   = '0;
    ch_clear  = '0;
`ifdef SNAIL_HIT_COUNT_EN
    cnt_sel   = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hit", 32'(hit), 32'd0);
    chk("rst_hit_ch", 32'(hit_ch), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    req_valid = 4'hF;
    #1;
    chk("rst_ptr", 32'(req_ready), 32'h1);
    req_valid = '0;
`ifdef SNAIL_HIT_COUNT_EN
    chk("rst_cnt", 32'(hit_cnt), 32'd0);
`endif
    reset  = 1'b0;
    mon_en = 1'b1;

    // Stream 0: 1101, then 101 to prove the post-hit state is S1.
    step(4'h1, 4'h1, 4'h0, 0, -1);
    step(4'h1, 4'h1, 4'h0, 0, -1);
    step(4'h1, 4'h0, 4'h0, 0, -1);
    step(4'h1, 4'h1, 4'h0, 0, 0);
    step(4'h1, 4'h1, 4'h0, 0, -1);
    step(4'h1, 4'h0, 4'h0, 0, -1);
    step(4'h1, 4'h1, 4'h0, 0, 0);
    idle();
    drained("t1");

    reset = 1'b1;
    #1;
    reset = 1'b0;

    // Streams 1 (1101) and 2 (1111) alternate; pending bits are held while stalled.
    step(4'h6, 4'h6, 4'h0, 1, -1);
    step(4'h6, 4'h6, 4'h0, 2, -1);
    step(4'h6, 4'h6, 4'h0, 1, -1);
    step(4'h6, 4'h4, 4'h0, 2, -1);
    step(4'h6, 4'h4, 4'h0, 1, -1);
    step(4'h6, 4'h6, 4'h0, 2, -1);
    step(4'h6, 4'h6, 4'h0, 1, 1);
    step(4'h4, 4'h4, 4'h0, 2, -1);
    idle();
    drained("t2");
    chk("hit_ch_hold", 32'(hit_ch), 32'd1);

    // Interleave streams 0 and 3; stream 0 context survives, pointer wraps 3->0.
    step(4'h1, 4'h1, 4'h0, 0, -1);
    step(4'h1, 4'h1, 4'h0, 0, -1);
    step(4'h1, 4'h0, 4'h0, 0, -1);
    step(4'h8, 4'h8, 4'h0, 3, -1);
    step(4'h8, 4'h8, 4'h0, 3, -1);
    step(4'h1, 4'h1, 4'h0, 0, 0);
    step(4'h9, 4'h0, 4'h0, 3, -1);
    step(4'h9, 4'h0, 4'h0, 0, -1);
    idle();
    drained("t3");

    // ch_clear on stream 0 in S3 with pointer at 0: stream 3 must win, stream 0 restarts.
    step(4'h1, 4'h1, 4'h0, 0, -1);
    step(4'h1, 4'h1, 4'h0, 0, -1);
    step(4'h1, 4'h0, 4'h0, 0, -1);
    step(4'h8, 4'h0, 4'h0, 3, -1);
    step(4'h9, 4'h1, 4'h1, 3, -1);
    step(4'h1, 4'h1, 4'h0, 0, -1);
    step(4'h1, 4'h1, 4'h0, 0, -1);
    step(4'h1, 4'h0, 4'h0, 0, -1);
    step(4'h1, 4'h1, 4'h0, 0, 0);
    idle();
    drained("t4");

    // Stream 2 reaches a hit, then reset lands mid-cycle and must clear everything at once.
    step(4'h0, 4'h0, 4'h4, -1, -1);
    step(4'h4, 4'h4, 4'h0, 2, -1);
    step(4'h4, 4'h4, 4'h0, 2, -1);
    step(4'h4, 4'h0, 4'h0, 2, -1);
    req_valid = 4'h4;
    req_bit   = 4'h4;
    e.ch = 2; e.cyc = cyc_n; gq.push_back(e);
    @(posedge clk);
    #1;
    req_valid = '0;
    chk("pre_rst_hit", 32'(hit), 32'd1);
    chk("pre_rst_hit_ch", 32'(hit_ch), 32'd2);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    mon_en = 1'b0;
    reset  = 1'b1;
    #1;
    chk("async_rst_hit", 32'(hit), 32'd0);
    chk("async_rst_hit_ch", 32'(hit_ch), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    req_valid = 4'hF;
    #1;
    chk("async_rst_ptr", 32'(req_ready), 32'h1);
    req_valid = '0;
    @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;
    step(4'h4, 4'h4, 4'h0, 2, -1);
    idle();
    drained("t5");

`ifdef SNAIL_HIT_COUNT_EN
    // 1101101... on stream 1: 260 overlapping hits, counter must stop at 255.
    step(4'h0, 4'h0, 4'h2, -1, -1);
    for (int k = 0; k < 781; k++) begin
      step(4'h2, ((k % 3) != 2) ? 4'h2 : 4'h0, 4'h0, 1, (k >= 3 && (k % 3) == 0) ? 1 : -1);
    end
    idle();
    drained("t6");
    cnt_sel = 2'd1;
    #1;
    chk("cnt_sat", 32'(hit_cnt), 32'd255);
    step(4'h0, 4'h0, 4'h2, -1, -1);
    chk("cnt_clear", 32'(hit_cnt), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
